// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// Carries the ovf flag only when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, s, c_out, busy
    );

    modport slave (
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, s, c_out, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit words one nibble per clock through a single 4-bit slice.
// NIBBLE_SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum;
    logic             last;

    always_comb begin
        a_sh  = a_q >> {cnt, 2'b00};
        b_sh  = b_q >> {cnt, 2'b00};
        a_nib = a_sh[3:0];
        b_nib = b_sh[3:0];
        sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        last  = (cnt == CW'(NIB - 1));
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_nxt;

    // Sign-bit rule: equivalent to carry-into-MSB xor carry-out-of-MSB.
    always_comb begin
        ovf_nxt = (a_nib[3] & b_nib[3] & ~sum[3])
                | (~a_nib[3] & ~b_nib[3] & sum[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == ADD && last) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry      <= bus.c_in;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    s_q[{cnt, 2'b00} +: 4] <= sum[3:0];
                    carry <= sum[4];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        c_out_q     <= sum[4];
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH=16.
// Checks ovf as well when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    nibble_serial_adder_if #(.WIDTH(16)) bus ();

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic do_op(
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  logic        ci,
        input  int          gap,
        input  bit          noise,
        output logic [15:0] s,
        output logic        co,
        output logic        ov,
        output int          lat,
        output int          busy_n
    );
        int w;
        w      = 0;
        busy_n = 0;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            bus.in_valid = 1'b0;
            lat = -1;
            s   = 'x;
            co  = 1'bx;
            ov  = 1'bx;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.c_in     = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            if (bus.busy) busy_n++;
            bus.out_ready = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.out_ready = 1'b0;
        if (lat >= 50) lat = -1;
        s  = bus.s;
        co = bus.c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ov = bus.ovf;
`else
        ov = 1'b0;
`endif
        repeat (gap) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.s !== 16'h0 || bus.c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b s=%h co=%b, want 1 0 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.s, bus.c_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] s;
        logic co, ov;
        int lat, bn;
        do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, s, co, ov, lat, bn);
        n_checks++;
        if (s !== 16'h5555 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sum: got %b_%h want 0_5555", co, s);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_checks++;
        if (bn !== 4) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d want 4", bn);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_release: vld=%b rdy=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        logic [15:0] s;
        logic co, ov;
        int lat, bn;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, s, co, ov, lat, bn);
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_sum: got %b_%h want 1_0000", co, s);
        end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_ovf: got %b want 0", ov);
        end
`endif
        do_op(16'h7FFF, 16'h0000, 1'b1, 0, 1'b0, s, co, ov, lat, bn);
        n_checks++;
        if (s !== 16'h8000 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL cin_sum: got %b_%h want 0_8000", co, s);
        end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ov !== 1'b1) begin
            n_fail++;
            $display("FAIL cin_ovf: got %b want 1", ov);
        end
`endif
    endtask

    task automatic test_backpressure();
        int w;
        int bad;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'h0101;
        bus.b = 16'h0202;
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d want 4", w);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.s !== 16'h3333 || bus.c_out !== 1'b0 ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0 || bus.s !== 16'h3333) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles, s=%h want 3333", bad, bus.s);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: busy=%b rdy=%b want 1 0",
                     bus.busy, bus.in_ready);
        end
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (bus.s !== 16'h0303 || bus.c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second: got %b_%h want 0_0303", bus.c_out, bus.s);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        logic co, ov;
        int lat, bn;
        bus.a        = 16'h1234;
        bus.b        = 16'h1111;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.s !== 16'h0 || bus.c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b s=%h co=%b, want 1 0 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.s, bus.c_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, s, co, ov, lat, bn);
        n_checks++;
        if (s !== 16'h1000 || co !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL post_reset_add: got %b_%h lat %0d want 0_1000 lat 4",
                     co, s, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, s;
        logic ci, co, ov;
        logic [16:0] ref_sum;
        int lat, bn, bad, done_n;
        bad    = 0;
        done_n = 0;
        for (int i = 0; i < 1000; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            if (i % 7 == 0) begin
                a = 16'hFFFF;
                b = 16'($urandom_range(0, 1));
            end
            ref_sum = {1'b0, a} + {1'b0, b} + {16'h0, ci};
            do_op(a, b, ci, int'($urandom_range(0, 3)), 1'b1,
                  s, co, ov, lat, bn);
            if (lat == 4) done_n++;
            n_checks++;
            if ({co, s} !== ref_sum || lat !== 4) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL stream[%0d]: got %h lat %0d want %h lat 4",
                             i, {co, s}, lat, ref_sum);
            end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            n_checks++;
            if (ov !== ((a[15] == b[15]) && (ref_sum[15] != a[15]))) begin
                n_fail++;
                $display("FAIL stream_ovf[%0d]: got %b", i, ov);
            end
`endif
        end
        n_checks++;
        if (done_n !== 1000) begin
            n_fail++;
            $display("FAIL stream_count: got %0d want 1000", done_n);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
